// File: rtl/pwm_cmd_regfile.sv
// SPI command register file: decodes a command byte, then writes or reads back
// PWM configuration registers. Define PWMREG_TIMEOUT_EN to abort stalled transfers.
//
//   state   | meaning
//   IDLE    | waiting for a command byte
//   WR_DATA | collecting write bytes LSB first into the shadow register
//   RD_DATA | streaming the sampled register out, one byte per received byte
module pwm_cmd_regfile #(
    parameter int N_CH        = 3,
    parameter int DATA_BYTES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         o_RX_DV,
    input  logic [7:0]                   o_RX_Byte,
    output logic                         i_TX_DV,
    output logic [7:0]                   i_TX_Byte,
    output logic [8*DATA_BYTES-1:0]      counter_value,
    output logic [8*DATA_BYTES-1:0]      prescaler,
    output logic [N_CH*8*DATA_BYTES-1:0] duty_cycle,
    output logic                         enable_pwm,
    output logic                         o_Cmd_Err
);

    localparam int          DW       = 8 * DATA_BYTES;
    localparam logic [6:0]  MAX_ADDR = 7'(2 + N_CH);
    localparam logic [2:0]  FULL_LEN = 3'(DATA_BYTES);

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA} state_t;

    state_t               state_q;
    logic [6:0]           addr_q;
    logic [2:0]           len_q;
    logic [2:0]           cnt_q;
    logic [DW-1:0]        shadow_q;
    logic [DW-1:0]        rd_q;
    logic                 tx_dv_q;
    logic [7:0]           tx_byte_q;
    logic                 err_q;
    logic                 en_q;
    logic [DW-1:0]        cnt_val_q;
    logic [DW-1:0]        presc_q;
    logic [N_CH*DW-1:0]   duty_q;
`ifdef PWMREG_TIMEOUT_EN
    logic [15:0]          idle_q;
`endif

    logic [6:0]           cmd_addr;
    logic [2:0]           cmd_len;
    logic [DW-1:0]        rd_snap_d;
    logic [DW-1:0]        shadow_d;

    assign cmd_addr = o_RX_Byte[6:0];
    assign cmd_len  = (cmd_addr == 7'd0) ? 3'd1 : FULL_LEN;

    // Register value as seen at command decode; reads stream from this snapshot.
    always_comb begin
        rd_snap_d = '0;
        case (cmd_addr)
            7'd0:    rd_snap_d[0] = en_q;
            7'd1:    rd_snap_d    = cnt_val_q;
            7'd2:    rd_snap_d    = presc_q;
            default: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (cmd_addr == 7'(3 + k)) rd_snap_d = duty_q[k*DW +: DW];
                end
            end
        endcase
    end

    always_comb begin
        shadow_d = shadow_q | (DW'(o_RX_Byte) << (8 * cnt_q));
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            rd_q      <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            cnt_val_q <= '0;
            presc_q   <= '0;
            duty_q    <= '0;
`ifdef PWMREG_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_q     <= 1'b0;
`ifdef PWMREG_TIMEOUT_EN
            if (state_q == IDLE || o_RX_DV) idle_q <= '0;
            else                            idle_q <= idle_q + 16'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (o_RX_DV) begin
                        if (cmd_addr > MAX_ADDR) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q   <= cmd_addr;
                            len_q    <= cmd_len;
                            cnt_q    <= '0;
                            shadow_q <= '0;
                            if (o_RX_Byte[7]) begin
                                state_q   <= RD_DATA;
                                tx_dv_q   <= 1'b1;
                                tx_byte_q <= rd_snap_d[7:0];
                                rd_q      <= rd_snap_d >> 8;
                            end else begin
                                state_q <= WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (o_RX_DV) begin
                        if (cnt_q == len_q - 3'd1) begin
                            // Whole value lands in one edge so no partial value is visible.
                            case (addr_q)
                                7'd0:    en_q      <= o_RX_Byte[0];
                                7'd1:    cnt_val_q <= shadow_d;
                                7'd2:    presc_q   <= shadow_d;
                                default: begin
                                    for (int k = 0; k < N_CH; k++) begin
                                        if (addr_q == 7'(3 + k)) duty_q[k*DW +: DW] <= shadow_d;
                                    end
                                end
                            endcase
                            state_q  <= IDLE;
                            cnt_q    <= '0;
                            shadow_q <= '0;
                        end else begin
                            shadow_q <= shadow_d;
                            cnt_q    <= cnt_q + 3'd1;
                        end
                    end
                end
                RD_DATA: begin
                    if (o_RX_DV) begin
                        if (cnt_q == len_q - 3'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            rd_q    <= '0;
                        end else begin
                            tx_dv_q   <= 1'b1;
                            tx_byte_q <= rd_q[7:0];
                            rd_q      <= rd_q >> 8;
                            cnt_q     <= cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef PWMREG_TIMEOUT_EN
            if (state_q != IDLE && !o_RX_DV && idle_q == 16'(TIMEOUT_CYC - 1)) begin
                state_q  <= IDLE;
                err_q    <= 1'b1;
                cnt_q    <= '0;
                shadow_q <= '0;
                rd_q     <= '0;
            end
`endif
        end
    end

    assign i_TX_DV       = tx_dv_q;
    assign i_TX_Byte     = tx_byte_q;
    assign counter_value = cnt_val_q;
    assign prescaler     = presc_q;
    assign duty_cycle    = duty_q;
    assign enable_pwm    = en_q;
    assign o_Cmd_Err     = err_q;

endmodule

// File: tb/tb_pwm_cmd_regfile.sv
// Bench for pwm_cmd_regfile: transaction-level model checked every cycle, plus
// literal expectations for the key sequences.
module tb_pwm_cmd_regfile;

    localparam int N_CH = 3;
    localparam int DB   = 4;
    localparam int DW   = 32;
    localparam int TO   = 1024;

    logic              clk     = 1'b0;
    logic              rst_l   = 1'b0;
    logic              rx_dv   = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic [DW-1:0]     cnt_v;
    logic [DW-1:0]     presc;
    logic [N_CH*DW-1:0] duty;
    logic              en;
    logic              err;

    pwm_cmd_regfile #(.N_CH(N_CH), .DATA_BYTES(DB), .TIMEOUT_CYC(TO)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .o_RX_DV      (rx_dv),
        .o_RX_Byte    (rx_byte),
        .i_TX_DV      (tx_dv),
        .i_TX_Byte    (tx_byte),
        .counter_value(cnt_v),
        .prescaler    (presc),
        .duty_cycle   (duty),
        .enable_pwm   (en),
        .o_Cmd_Err    (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction model: registers indexed by address, current transfer as byte counts.
    logic [31:0] m_reg [0:7];
    int          m_mode = 0;          // 0 idle, 1 writing, 2 reading
    int          m_addr = 0;
    int          m_len  = 0;
    int          m_cnt  = 0;
    int          m_idle = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_snap   = '0;
    logic        m_tx_dv   = 1'b0;
    logic [7:0]  m_tx_byte = 8'h00;
    logic        m_err     = 1'b0;

    task automatic model_step();
        int a;
        m_tx_dv   = 1'b0;
        m_tx_byte = 8'h00;
        m_err     = 1'b0;
        if (!rst_l) begin
            m_mode = 0; m_cnt = 0; m_idle = 0; m_shadow = '0;
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
        end else if (m_mode == 0) begin
            if (rx_dv) begin
                a = int'(rx_byte[6:0]);
                if (a > 2 + N_CH) m_err = 1'b1;
                else begin
                    m_addr = a; m_len = (a == 0) ? 1 : DB; m_cnt = 0; m_idle = 0; m_shadow = '0;
                    if (rx_byte[7]) begin
                        m_mode = 2; m_snap = m_reg[a];
                        m_tx_dv = 1'b1; m_tx_byte = m_snap[7:0];
                    end else m_mode = 1;
                end
            end
        end else if (rx_dv) begin
            m_idle = 0;
            if (m_mode == 1) begin
                m_shadow = m_shadow | (32'(rx_byte) << (8 * m_cnt));
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_reg[m_addr] = (m_addr == 0) ? {31'b0, m_shadow[0]} : m_shadow;
                    m_mode = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt < m_len) begin
                    m_tx_dv = 1'b1; m_tx_byte = 8'(m_snap >> (8 * m_cnt));
                end else m_mode = 0;
            end
        end else begin
`ifdef PWMREG_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin m_mode = 0; m_err = 1'b1; end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("tx_dv",     tx_dv,   m_tx_dv);
            chk("tx_byte",   tx_byte, m_tx_byte);
            chk("cmd_err",   err,     m_err);
            chk("enable",    en,      m_reg[0][0]);
            chk("counter",   cnt_v,   m_reg[1]);
            chk("prescaler", presc,   m_reg[2]);
            chk("duty",      duty,    {m_reg[5], m_reg[4], m_reg[3]});
        end
    end

    logic [7:0] tx_log[$];
    int         err_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (tx_dv) tx_log.push_back(tx_byte);
        if (err) err_cnt++;
    end

    // All drive tasks start and end 2 time units after a rising edge.
    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #2;
        rx_dv = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_counter", cnt_v, 32'h0);
        chk("reset_duty", duty, 96'h0);
        chk("reset_tx", {tx_dv, tx_byte, en, err}, 11'h0);
        @(posedge clk); #2;
        rst_l = 1'b1;
        idle(2);

        // counter_value write, commit exactly one cycle after last byte
        send(8'h01); send(8'h78); send(8'h56); send(8'h34);
        rx_dv = 1'b1; rx_byte = 8'h12;
        @(negedge clk);
        chk("counter_before_commit", cnt_v, 32'h0);
        @(posedge clk); #2;
        rx_dv = 1'b0; rx_byte = 8'h00;
        @(negedge clk);
        chk("counter_after_commit", cnt_v, 32'h12345678);
        idle(2);

        // duty channel 2 write then read back
        send(8'h05); send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
        idle(1);
        tx_log.delete();
        send(8'h85); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        idle(3);
        chk("rd_pulse_count", 128'(tx_log.size()), 128'd4);
        if (tx_log.size() == 4) begin
            chk("rd_byte0", tx_log[0], 8'hDD);
            chk("rd_byte1", tx_log[1], 8'hCC);
            chk("rd_byte2", tx_log[2], 8'hBB);
            chk("rd_byte3", tx_log[3], 8'hAA);
        end
        chk("duty_ch2", duty[95:64], 32'hAABBCCDD);

        // CTRL: only bit0 matters
        send(8'h00); send(8'h03);
        idle(1);
        chk("enable_set", en, 1'b1);
        tx_log.delete();
        send(8'h80); send(8'h5A);
        idle(2);
        chk("ctrl_rd_count", 128'(tx_log.size()), 128'd1);
        if (tx_log.size() == 1) chk("ctrl_rd_byte", tx_log[0], 8'h01);
        send(8'h00); send(8'h02);
        idle(1);
        chk("enable_clr", en, 1'b0);

        // illegal address, then a normal prescaler write
        send(8'h06);
        idle(2);
        chk("illegal_err_cnt", 128'(err_cnt), 128'd1);
        chk("illegal_counter_kept", cnt_v, 32'h12345678);
        send(8'h02); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(1);
        chk("prescaler_write", presc, 32'hDEADBEEF);

`ifdef PWMREG_TIMEOUT_EN
        // one cycle short of the limit must not abort
        send(8'h03); idle(TO - 1);
        send(8'hAA); idle(TO - 1);
        send(8'hBB); send(8'hCC); send(8'hDD);
        idle(1);
        chk("no_abort_duty0", duty[31:0], 32'hDDCCBBAA);
        chk("no_abort_err_cnt", 128'(err_cnt), 128'd1);
        // abort, then a command in the first cycle back in IDLE
        send(8'h02); send(8'h11); send(8'h22);
        idle(TO);
        tx_log.delete();
        send(8'h82); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        chk("abort_err_cnt", 128'(err_cnt), 128'd2);
        chk("abort_prescaler", presc, 32'hDEADBEEF);
        chk("post_abort_rd_count", 128'(tx_log.size()), 128'd4);
        if (tx_log.size() == 4) chk("post_abort_rd_byte3", tx_log[3], 8'hDE);
`endif

        // reset mid-write, with a byte presented during reset
        send(8'h03); send(8'h11); send(8'h22);
        rst_l = 1'b0; rx_dv = 1'b1; rx_byte = 8'h81;
        @(posedge clk); #2;
        rst_l = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        @(negedge clk);
        chk("rst_prescaler", presc, 32'h0);
        chk("rst_duty", duty, 96'h0);
        idle(2);
        chk("rst_no_tx", tx_dv, 1'b0);
        send(8'h02); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        idle(1);
        chk("post_rst_write", presc, 32'h11223344);
        chk("post_rst_duty0", duty[31:0], 32'h0);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
